// File: rtl/xalu_mdu_if.sv
// ============================================================================
// Module : xalu_mdu_if
// Brief  : E-stage multiply/divide bus between the pipeline and xalu_mdu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface xalu_mdu_if;
    logic [3:0]  XALUOp;
    logic [31:0] XALUa;
    logic [31:0] XALUb;
    logic [31:0] XALU_Out;
    logic        Busy;

    modport master (
        output XALUOp,
        output XALUa,
        output XALUb,
        input  XALU_Out,
        input  Busy
    );

    modport slave (
        input  XALUOp,
        input  XALUa,
        input  XALUb,
        output XALU_Out,
        output Busy
    );
endinterface

`default_nettype wire

// File: rtl/xalu_mdu.sv
// ============================================================================
// Module : xalu_mdu
// Brief  : HI/LO owner for mult/div/mthi/mtlo/mfhi/mflo with a fixed-latency
//          Busy window; optional madd/msub enabled by `XALU_MADD_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module xalu_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic  clk,
    input  wire logic  reset,
    xalu_mdu_if.slave  bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MSUB  = 4'd10;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    logic [0:0]  state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [31:0] hi_q,      hi_d;
    logic [31:0] lo_q,      lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_we_q, pend_we_d;

    logic [3:0]  w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_is_mult;
    logic        w_is_div;

    assign w_op = bus.XALUOp;
    assign w_a  = bus.XALUa;
    assign w_b  = bus.XALUb;

    always_comb begin
        w_is_mult = (w_op == OP_MULT) || (w_op == OP_MULTU);
`ifdef XALU_MADD_EN
        w_is_mult = w_is_mult || (w_op == OP_MADD) || (w_op == OP_MSUB);
`endif
        w_is_div  = (w_op == OP_DIV) || (w_op == OP_DIVU);
    end

    // ------------------------------------------------------------------
    // Datapath: result is computed at start and parked in pend_* regs
    // ------------------------------------------------------------------
    logic [63:0] w_a_sx;
    logic [63:0] w_b_sx;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_hilo;
    logic [63:0] w_madd;
    logic [63:0] w_msub;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic [31:0] w_div_b;
    logic [31:0] w_quo_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quo_u;
    logic [31:0] w_rem_u;

    assign w_a_sx   = {{32{w_a[31]}}, w_a};
    assign w_b_sx   = {{32{w_b[31]}}, w_b};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {32'd0, w_a} * {32'd0, w_b};
    assign w_hilo   = {hi_q, lo_q};
    assign w_madd   = w_hilo + w_prod_s;
    assign w_msub   = w_hilo - w_prod_s;

    // 0x80000000 / -1 is steered to a divide-by-one, giving LO=a, HI=0.
    assign w_div_zero = (w_b == 32'd0);
    assign w_div_ovf  = (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
    assign w_div_b    = (w_div_zero || w_div_ovf) ? 32'd1 : w_b;
    assign w_quo_s    = $signed(w_a) / $signed(w_div_b);
    assign w_rem_s    = $signed(w_a) % $signed(w_div_b);
    assign w_quo_u    = w_a / w_div_b;
    assign w_rem_u    = w_a % w_div_b;

    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_we;

    always_comb begin
        w_res_hi = hi_q;
        w_res_lo = lo_q;
        w_res_we = 1'b0;
        case (w_op)
            OP_MULT: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_we             = 1'b1;
            end
            OP_MULTU: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_we             = 1'b1;
            end
            OP_DIV: begin
                w_res_hi = w_rem_s;
                w_res_lo = w_quo_s;
                w_res_we = !w_div_zero;
            end
            OP_DIVU: begin
                w_res_hi = w_rem_u;
                w_res_lo = w_quo_u;
                w_res_we = !w_div_zero;
            end
            OP_MADD: begin
                {w_res_hi, w_res_lo} = w_madd;
                w_res_we             = 1'b1;
            end
            OP_MSUB: begin
                {w_res_hi, w_res_lo} = w_msub;
                w_res_we             = 1'b1;
            end
            default: begin
                w_res_we = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        case (state_q)
            S_RUN: begin
                // All non-read ops are dropped while running.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d   = S_IDLE;
                    cnt_d     = 4'd0;
                    pend_we_d = 1'b0;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                if (w_is_mult || w_is_div) begin
                    state_d   = S_RUN;
                    cnt_d     = w_is_div ? DIV_N : MULT_N;
                    pend_hi_d = w_res_hi;
                    pend_lo_d = w_res_lo;
                    pend_we_d = w_res_we;
                end else if (w_op == OP_MTHI) begin
                    hi_d = w_a;
                end else if (w_op == OP_MTLO) begin
                    lo_d = w_a;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.XALU_Out = 32'd0;
        if (w_op == OP_MFHI) begin
            bus.XALU_Out = hi_q;
        end else if (w_op == OP_MFLO) begin
            bus.XALU_Out = lo_q;
        end
        bus.Busy = (state_q == S_RUN);
    end

endmodule

`default_nettype wire

// File: tb/tb_xalu_mdu.sv
// ============================================================================
// Module : tb_xalu_mdu
// Brief  : Vector table plus hand sequences for xalu_mdu (scoreboarded HI/LO).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xalu_mdu;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    xalu_mdu_if bus ();

    xalu_mdu #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t tbl[$];
    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", nm, act, req);
        end
    endtask

    // Called just after a falling edge; finishes well before the rising edge.
    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        bus.XALUOp = 4'd7;
        #1 h = bus.XALU_Out;
        bus.XALUOp = 4'd8;
        #1 l = bus.XALU_Out;
        bus.XALUOp = 4'd0;
    endtask

    task automatic compare_pop(input string nm);
        exp_t        e;
        logic [31:0] h, l;
        if (expq.size() == 0) begin
            check({nm, " scoreboard empty"}, 32'd1, 32'd0);
            return;
        end
        e = expq.pop_front();
        read_hilo(h, l);
        check({nm, " HI"}, h, e.hi);
        check({nm, " LO"}, l, e.lo);
    endtask

    task automatic wait_idle(input int start, output int cyc);
        cyc = start;
        while (bus.Busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        bus.XALUOp = v.op;
        bus.XALUa  = v.a;
        bus.XALUb  = v.b;
        expq.push_back('{v.hi, v.lo});
        @(negedge clk);
        bus.XALUOp = 4'd0;
        wait_idle(0, cyc);
        check({v.name, " busy cycles"}, 32'(cyc), 32'(v.cycles));
        compare_pop(v.name);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.XALUOp = op;
        bus.XALUa  = a;
        bus.XALUb  = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cyc;
        logic [31:0] h, l;

        tbl.push_back('{"mult neg",    4'd1,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5});
        tbl.push_back('{"multu max",   4'd2,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5});
        tbl.push_back('{"divu 7/2",    4'd4,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, 10});
        tbl.push_back('{"div -7/2",    4'd3,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        tbl.push_back('{"div ovf",     4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10});
        tbl.push_back('{"div by 0",    4'd3,  32'd5,         32'd0,         32'h0000_0000, 32'h8000_0000, 10});
        tbl.push_back('{"divu big",    4'd4,  32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 32'h0FFF_FFFF, 10});
        tbl.push_back('{"divu by 0",   4'd4,  32'd9,         32'd0,         32'h0000_000F, 32'h0FFF_FFFF, 10});
        tbl.push_back('{"div 7/-2",    4'd3,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10});
        tbl.push_back('{"mult minsq",  4'd1,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5});
        tbl.push_back('{"mthi",        4'd5,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'h0000_0000, 0});
        tbl.push_back('{"mtlo",        4'd6,  32'h0000_ABCD, 32'd0,         32'h0000_1234, 32'h0000_ABCD, 0});
        tbl.push_back('{"op 12 nop",   4'd12, 32'hDEAD_BEEF, 32'd1,         32'h0000_1234, 32'h0000_ABCD, 0});
        tbl.push_back('{"mthi 0",      4'd5,  32'd0,         32'd0,         32'h0000_0000, 32'h0000_ABCD, 0});
        tbl.push_back('{"mtlo 10",     4'd6,  32'd10,        32'd0,         32'h0000_0000, 32'h0000_000A, 0});
`ifdef XALU_MADD_EN
        tbl.push_back('{"madd",        4'd9,  32'hFFFF_FFFF, 32'd3,         32'h0000_0000, 32'h0000_0007, 5});
        tbl.push_back('{"msub",        4'd10, 32'd2,         32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 5});
`else
        tbl.push_back('{"op 9 nop",    4'd9,  32'hFFFF_FFFF, 32'd3,         32'h0000_0000, 32'h0000_000A, 0});
        tbl.push_back('{"op 10 nop",   4'd10, 32'd2,         32'd5,         32'h0000_0000, 32'h0000_000A, 0});
`endif

        reset = 1'b0;
        drive(4'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("reset Busy", 32'(bus.Busy), 32'd0);
        read_hilo(h, l);
        check("reset HI", h, 32'd0);
        check("reset LO", l, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end

        // Interference: writes and starts during RUN are dropped, mfhi sees old HI.
        drive(4'd5, 32'h55, 32'd0);
        @(negedge clk);
        drive(4'd1, 32'd6, 32'd7);
        expq.push_back('{32'd0, 32'd42});
        @(negedge clk);
        drive(4'd5, 32'h1234, 32'd0);
        @(negedge clk);
        drive(4'd3, 32'd9, 32'd3);
        @(negedge clk);
        bus.XALUOp = 4'd7;
        #1 check("mfhi during run", bus.XALU_Out, 32'h55);
        bus.XALUOp = 4'd0;
        wait_idle(2, cyc);
        check("interference busy cycles", 32'(cyc), 32'd5);
        compare_pop("interference");

        // Start presented on the RUN->IDLE edge is ignored, taken next cycle.
        drive(4'd2, 32'd3, 32'd4);
        expq.push_back('{32'd0, 32'd12});
        @(negedge clk);
        bus.XALUOp = 4'd0;
        repeat (4) @(negedge clk);
        check("last busy cycle", 32'(bus.Busy), 32'd1);
        drive(4'd1, 32'd5, 32'd5);
        @(negedge clk);
        check("late start ignored", 32'(bus.Busy), 32'd0);
        compare_pop("multu before late start");
        drive(4'd1, 32'd5, 32'd5);
        expq.push_back('{32'd0, 32'd25});
        @(negedge clk);
        bus.XALUOp = 4'd0;
        check("retry start accepted", 32'(bus.Busy), 32'd1);
        wait_idle(0, cyc);
        check("retry busy cycles", 32'(cyc), 32'd5);
        compare_pop("retry mult");

        // Reset in the third Busy cycle of a divide.
        drive(4'd5, 32'h77, 32'd0);
        @(negedge clk);
        drive(4'd3, 32'd100, 32'd7);
        @(negedge clk);
        bus.XALUOp = 4'd0;
        repeat (2) @(negedge clk);
        check("busy before reset", 32'(bus.Busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("busy after reset", 32'(bus.Busy), 32'd0);
        read_hilo(h, l);
        check("HI after reset", h, 32'd0);
        check("LO after reset", l, 32'd0);
        repeat (12) @(negedge clk);
        check("busy long after reset", 32'(bus.Busy), 32'd0);
        read_hilo(h, l);
        check("HI no late write", h, 32'd0);
        check("LO no late write", l, 32'd0);

        // Reset pulse between edges must not disturb state.
        drive(4'd6, 32'h99, 32'd0);
        @(negedge clk);
        bus.XALUOp = 4'd0;
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge clk);
        read_hilo(h, l);
        check("LO after glitch", l, 32'h99);
        check("HI after glitch", h, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
